if_inst_queue: RTL and testbench

- Dual-entry-per-cycle instruction queue on the receive side of the IF stage's two-line output bus; sits between IF and ID.
- Accepts up to two fetched instructions per cycle (line1/line2) with PC and exception info.
- Buffers them in a circular FIFO and presents up to two in order to ID.
- Decouples fetch from decode stalls; cleared by exception or branch flush.

---
 rtl/if_inst_queue.sv | 86 ++++++++
 tb/tb_if_inst_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/if_inst_queue.sv
// Two-write/two-read circular instruction queue between IF and ID; 1-cycle write-to-read, no bypass.
// Backpressure: accepts a write only with >=2 free slots; ID stalls via next_allowin_i; either flush empties it.
module if_inst_queue #(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int ENTRY_W = 85
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               excep_flush_i,
    input  logic               branch_flush_i,
    input  logic               line1_wvalid_i,
    input  logic               line2_wvalid_i,
    input  logic [ENTRY_W-1:0] line1_wdata_i,
    input  logic [ENTRY_W-1:0] line2_wdata_i,
    output logic               now_allowin_o,
    input  logic               next_allowin_i,
    output logic               line1_to_next_valid_o,
    output logic               line2_to_next_valid_o,
    output logic [ENTRY_W-1:0] line1_rdata_o,
    output logic [ENTRY_W-1:0] line2_rdata_o,
    output logic [PTR_W:0]     count_o,
    output logic               empty_o
);

    localparam logic [PTR_W:0]   DEPTH_W = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   TWO_W   = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W:0]     count;
    logic               flush;
    logic [1:0]         push_n;
    logic [1:0]         pop_n;
    logic [PTR_W-1:0]   wptr_p1;
    logic [PTR_W-1:0]   rptr_p1;

    assign flush   = excep_flush_i | branch_flush_i;
    assign wptr_p1 = wptr + ONE_P;
    assign rptr_p1 = rptr + ONE_P;

    // Credit check uses the registered count only, so it never depends on ID's accept.
    assign now_allowin_o = (DEPTH_W - count) >= TWO_W;

    assign line1_to_next_valid_o = (count != '0) & ~flush;
    assign line2_to_next_valid_o = (count >= TWO_W) & ~flush;
    assign line1_rdata_o         = mem[rptr];
    assign line2_rdata_o         = mem[rptr_p1];
    assign count_o               = count;
    assign empty_o               = (count == '0);

    always_comb begin
        push_n = 2'd0;
        if (!rst && !flush && now_allowin_o && line1_wvalid_i)
            push_n = line2_wvalid_i ? 2'd2 : 2'd1;
    end

    always_comb begin
        pop_n = 2'd0;
        if (next_allowin_i)
            pop_n = {1'b0, line1_to_next_valid_o} + {1'b0, line2_to_next_valid_o};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(push_n);
            rptr  <= rptr + PTR_W'(pop_n);
            count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
    end

    // Payload storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0)
            mem[wptr] <= line1_wdata_i;
        if (push_n == 2'd2)
            mem[wptr_p1] <= line2_wdata_i;
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed vector table plus a queue-model wrap-around run for if_inst_queue.
module tb_if_inst_queue;

    logic        clk = 1'b0;
    logic        rst, excep_flush_i, branch_flush_i;
    logic        line1_wvalid_i, line2_wvalid_i, next_allowin_i;
    logic [84:0] line1_wdata_i, line2_wdata_i;
    logic        now_allowin_o, line1_to_next_valid_o, line2_to_next_valid_o, empty_o;
    logic [84:0] line1_rdata_o, line2_rdata_o;
    logic [3:0]  count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_inst_queue #(.DEPTH(8), .PTR_W(3), .ENTRY_W(85)) dut (
        .clk(clk), .rst(rst),
        .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i),
        .line1_wvalid_i(line1_wvalid_i), .line2_wvalid_i(line2_wvalid_i),
        .line1_wdata_i(line1_wdata_i), .line2_wdata_i(line2_wdata_i),
        .now_allowin_o(now_allowin_o), .next_allowin_i(next_allowin_i),
        .line1_to_next_valid_o(line1_to_next_valid_o),
        .line2_to_next_valid_o(line2_to_next_valid_o),
        .line1_rdata_o(line1_rdata_o), .line2_rdata_o(line2_rdata_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    typedef struct {
        logic        rst, bfl, efl, w1, w2, na;
        logic [31:0] p1, p2;
        logic        chk, v1, v2;
        logic [31:0] e1, e2;
        int          cnt;
        logic        allow;
    } vec_t;

    vec_t vecs[$];

    // Payload derived from the PC so every field is distinct and checkable.
    function automatic logic [84:0] pay(input logic [31:0] pc);
        return {pc[3], pc[23:4], pc, ~pc};
    endfunction

    function automatic vec_t mk(input logic r, input logic bf, input logic ef,
                                input logic w1, input logic w2, input logic na,
                                input logic [31:0] p1, input logic [31:0] p2,
                                input logic chk, input logic v1, input logic v2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input int cnt, input logic allow);
        vec_t v;
        v.rst = r; v.bfl = bf; v.efl = ef; v.w1 = w1; v.w2 = w2; v.na = na;
        v.p1 = p1; v.p2 = p2; v.chk = chk; v.v1 = v1; v.v2 = v2;
        v.e1 = e1; v.e2 = e2; v.cnt = cnt; v.allow = allow;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic bf, input logic ef, input logic w1,
                         input logic w2, input logic na, input logic [31:0] p1, input logic [31:0] p2);
        rst = r; branch_flush_i = bf; excep_flush_i = ef;
        line1_wvalid_i = w1; line2_wvalid_i = w2; next_allowin_i = na;
        line1_wdata_i = pay(p1); line2_wdata_i = pay(p2);
    endtask

    task automatic check_outs(input string tag, input logic v1, input logic v2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input int cnt, input logic allow);
        check({tag, ".count"}, 128'(count_o), 128'(cnt));
        check({tag, ".empty"}, 128'(empty_o), 128'(cnt == 0));
        check({tag, ".allow"}, 128'(now_allowin_o), 128'(allow));
        check({tag, ".v1"}, 128'(line1_to_next_valid_o), 128'(v1));
        check({tag, ".v2"}, 128'(line2_to_next_valid_o), 128'(v2));
        if (v1) check({tag, ".d1"}, 128'(line1_rdata_o), 128'(pay(e1)));
        if (v2) check({tag, ".d2"}, 128'(line2_rdata_o), 128'(pay(e2)));
    endtask

    localparam logic [31:0] A = 32'h1c000000;
    localparam logic [31:0] F = 32'h1c000100;
    localparam logic [31:0] G = 32'h1c000200;

    initial begin
        logic [31:0] q[$];
        logic [31:0] next_pc, last_pop;
        int          npop;
        logic        allow;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        //             rst bfl efl w1 w2 na  p1        p2        chk v1 v2 e1       e2       cnt allow
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,        0,        0,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0,        1,  0, 0, 0,       0,       0, 1));
        // dual write then dual read
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, A,        A+4,      1,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  1, 1, A,       A+4,     2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  0, 0, 0,       0,       0, 1));
        // fill to 7, further push dropped
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, F,        F+4,      1,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, F+8,      F+12,     1,  1, 1, F,       F+4,     2, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, F+16,     F+20,     1,  1, 1, F,       F+4,     4, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, F+24,     F+28,     1,  1, 1, F,       F+4,     6, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, F+28,     F+32,     1,  1, 1, F,       F+4,     7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0,        1,  1, 1, F,       F+4,     7, 0));
        // drain to 3, then simultaneous push 2 / pop 2
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  1, 1, F,       F+4,     7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  1, 1, F+8,     F+12,    5, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, G,        G+4,      1,  1, 1, F+16,    F+20,    3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0,        1,  1, 1, F+24,    G,       3, 1));
        // grow to 5, then branch flush with push and accept
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, G+8,      G+12,     1,  1, 1, F+24,    G,       3, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, G+16,     G+20,     1,  0, 0, 0,       0,       5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  0, 0, 0,       0,       0, 1));
        // exception flush
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, G+32,     G+36,     1,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,        0,        1,  0, 0, 0,       0,       2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  0, 0, 0,       0,       0, 1));
        // reset mid-stream beats push and pop
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, G+48,     0,        1,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, G+64,     G+68,     1,  1, 0, G+48,    0,       1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,        0,        1,  0, 0, 0,       0,       0, 1));
        // line2 without line1 is ignored
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, G+80,     G+84,     1,  0, 0, 0,       0,       0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,        0,        1,  0, 0, 0,       0,       0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].bfl, vecs[i].efl, vecs[i].w1, vecs[i].w2,
                  vecs[i].na, vecs[i].p1, vecs[i].p2);
            #1;
            if (vecs[i].chk)
                check_outs($sformatf("vec%0d", i), vecs[i].v1, vecs[i].v2, vecs[i].e1,
                           vecs[i].e2, vecs[i].cnt, vecs[i].allow);
        end

        // Wrap-around: single pushes every cycle, ID stalls every third cycle.
        next_pc  = 32'h1c001000;
        last_pop = next_pc - 4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (c % 3) != 0, next_pc, 32'h0);
            #1;
            allow = (8 - q.size()) >= 2;
            check_outs($sformatf("wrap%0d", c), q.size() >= 1, q.size() >= 2,
                       (q.size() >= 1) ? q[0] : 32'h0, (q.size() >= 2) ? q[1] : 32'h0,
                       q.size(), allow);
            npop = ((c % 3) != 0) ? ((q.size() >= 2) ? 2 : q.size()) : 0;
            for (int k = 0; k < npop; k++) begin
                check($sformatf("wrap%0d.order", c), 128'(q[0]), 128'(last_pop + 4));
                last_pop = q.pop_front();
            end
            if (allow) begin
                q.push_back(next_pc);
                next_pc = next_pc + 4;
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("wrap.final_count", 128'(count_o), 128'(q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
